// File: rtl/counter_monitor.sv
// Watches an up/down counter's output and checks each step against the value
// predicted from the previous sample, tracking lock, mismatches and wraps.
module counter_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             mode,
    input  logic             ctr_rst,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count,
    output logic             dir_obs
);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int CW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0]    LIMIT = CW'(ERR_LIMIT);
    localparam logic [WIDTH-1:0] MAX_Q = '1;
    localparam logic [WIDTH-1:0] MIN_Q = '0;

    state_t           state;
    logic [WIDTH-1:0] prev_q;
    logic             prev_mode;
    logic             prev_rst;
    logic [CW-1:0]    consec;

    logic [WIDTH-1:0] expected;
    logic             match;
    logic             wrap_hit;
    logic [CW-1:0]    consec_next;
    logic             limit_hit;

    // Prediction of the current sample from the previous one; a counter reset
    // seen last sample forces zero regardless of direction.
    always_comb begin
        expected = MIN_Q;
        if (!prev_rst) begin
            if (prev_mode) begin
                expected = prev_q + 1'b1;
            end else begin
                expected = prev_q - 1'b1;
            end
        end
        match       = (q_in == expected);
        wrap_hit    = !prev_rst &&
                      ((prev_mode  && (prev_q == MAX_Q) && (q_in == MIN_Q)) ||
                       (!prev_mode && (prev_q == MIN_Q) && (q_in == MAX_Q)));
        consec_next = consec + 1'b1;
        limit_hit   = (consec_next == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= UNLOCK;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= 8'd0;
            wrap_count <= 8'd0;
            dir_obs    <= 1'b0;
            consec     <= '0;
            prev_q     <= '0;
            prev_mode  <= 1'b0;
            prev_rst   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (en) begin
                prev_q    <= q_in;
                prev_mode <= mode;
                prev_rst  <= ctr_rst;
                case (state)
                    UNLOCK: begin
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                    SYNC: begin
                        if (match) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            consec <= '0;
                            if (!prev_rst) begin
                                dir_obs <= prev_mode;
                            end
                            if (wrap_hit && (wrap_count != 8'hFF)) begin
                                wrap_count <= wrap_count + 8'd1;
                            end
                        end else begin
                            err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                            // Too many mismatches in a row: give up the lock and resync.
                            if (limit_hit) begin
                                state  <= UNLOCK;
                                locked <= 1'b0;
                                consec <= '0;
                            end else begin
                                consec <= consec_next;
                            end
                        end
                    end
                    default: begin
                        state  <= UNLOCK;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
